// File: rtl/reg_bank_16x8.sv
// Sixteen 8-bit registers with one write-back port, one increment/decrement port,
// synchronous clear and a per-register dirty bitmap; all outputs come straight from flops.
module reg_bank_16x8 #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        step_en,
    input  logic        step_dir,
    input  logic [3:0]  step_addr,
    input  logic        clr_all,
    input  logic        dirty_clr,
    output logic [7:0]  r0,
    output logic [7:0]  r1,
    output logic [7:0]  r2,
    output logic [7:0]  r3,
    output logic [7:0]  r4,
    output logic [7:0]  r5,
    output logic [7:0]  r6,
    output logic [7:0]  r7,
    output logic [7:0]  r8,
    output logic [7:0]  r9,
    output logic [7:0]  r10,
    output logic [7:0]  r11,
    output logic [7:0]  r12,
    output logic [7:0]  r13,
    output logic [7:0]  r14,
    output logic [7:0]  r15,
    output logic [15:0] dirty,
    output logic        step_wrap
);

    logic [15:0][7:0] regs_reg;
    logic [15:0][7:0] regs_next;
    logic [15:0]      dirty_reg;
    logic [15:0]      dirty_next;
    logic             wrap_reg;
    logic             wrap_next;

    // A step aimed at the register being written this cycle is dropped.
    logic       step_go;
    logic [7:0] step_val;

    assign step_go  = step_en && !(wr_en && (wr_addr == step_addr));
    assign step_val = regs_reg[step_addr];

    always_comb begin
        wrap_next = 1'b0;
        if (!clr_all && step_go) begin
            wrap_next = step_dir ? (step_val == 8'hFF) : (step_val == 8'h00);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            logic wr_hit;
            logic step_hit;

            assign wr_hit   = wr_en && (wr_addr == 4'(gi));
            assign step_hit = step_go && (step_addr == 4'(gi));

            always_comb begin
                regs_next[gi]  = regs_reg[gi];
                dirty_next[gi] = dirty_clr ? 1'b0 : dirty_reg[gi];
                if (clr_all) begin
                    regs_next[gi]  = RESET_VAL;
                    dirty_next[gi] = 1'b0;
                end else if (wr_hit) begin
                    regs_next[gi]  = wr_data;
                    dirty_next[gi] = 1'b1;
                end else if (step_hit) begin
                    regs_next[gi]  = step_dir ? regs_reg[gi] + 8'd1 : regs_reg[gi] - 8'd1;
                    dirty_next[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_reg[i] <= RESET_VAL;
            end
            dirty_reg <= 16'h0000;
            wrap_reg  <= 1'b0;
        end else begin
            regs_reg  <= regs_next;
            dirty_reg <= dirty_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign r0        = regs_reg[0];
    assign r1        = regs_reg[1];
    assign r2        = regs_reg[2];
    assign r3        = regs_reg[3];
    assign r4        = regs_reg[4];
    assign r5        = regs_reg[5];
    assign r6        = regs_reg[6];
    assign r7        = regs_reg[7];
    assign r8        = regs_reg[8];
    assign r9        = regs_reg[9];
    assign r10       = regs_reg[10];
    assign r11       = regs_reg[11];
    assign r12       = regs_reg[12];
    assign r13       = regs_reg[13];
    assign r14       = regs_reg[14];
    assign r15       = regs_reg[15];
    assign dirty     = dirty_reg;
    assign step_wrap = wrap_reg;

endmodule
